mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Central FSM that sequences one shift-add multiplication per start pulse.
//  It drives the multiplicand PIPO load, multiplier shift-register load, SPM clear and product SIPO shift enable.
//  It replaces the ad-hoc loading/multiplication counter pair and reports busy/done status to the top-level wrapper.
//  It runs on the divided system clock; start comes from the debounced BTNC pulse.
// PARAMETERS
//  WIDTH        8   operand width; multiply phase lasts 2*WIDTH cycles
//  LOAD_CYCLES  6   cycles spent in LOAD phase (multiplier shift-in / SPM clear), >=1
// PORTS
//  clk           in   1                    system (divided) clock, rising edge
//  rst           in   1                    asynchronous reset, active-low
//  clr           in   1                    synchronous abort/clear, active-high
//  start         in   1                    1-cycle request pulse to begin a multiplication
//  load_x        out  1                    multiplicand register load strobe
//  load_y        out  1                    multiplier shift-register load enable
//  spm_clr       out  1                    SPM / product SIPO clear
//  shift_en      out  1                    product SIPO shift enable (serial product valid)
//  busy          out  1                    high in LOAD or MULT
//  done          out  1                    1-cycle pulse, first cycle of DONE
//  result_valid  out  1                    level: product register holds a complete result
//  phase_cnt     out  $clog2(2*WIDTH+1)    current cycle index within the active phase
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, phase_cnt=0, all outputs 0.
//  States: IDLE, LOAD, MULT, DONE. All outputs are registered, Moore-style.
//  IDLE:
//   - start=1 -> LOAD next cycle.
//  LOAD:
//   - Lasts exactly LOAD_CYCLES cycles.
//   - load_y=1 and spm_clr=1 throughout; load_x=1 on the first LOAD cycle only.
//   - phase_cnt counts 0..LOAD_CYCLES-1.
//   - Exit to MULT.
//  MULT:
//   - Lasts exactly 2*WIDTH cycles with shift_en=1; phase_cnt counts 0..2*WIDTH-1.
//   - Exit to DONE.
//  DONE:
//   - done=1 for the first DONE cycle only; result_valid=1 held while in DONE.
//   - Stays in DONE until start or clr.
//   - start in DONE -> LOAD next cycle; result_valid drops on the same edge.
//  busy=1 exactly while the state is LOAD or MULT.
//  start during LOAD or MULT is ignored and not queued.
//  clr=1 (any state) -> IDLE next edge: phase_cnt=0, all outputs 0, result_valid cleared.
//   - clr has priority over a simultaneous start; that start is dropped.
//  Async reset mid-operation aborts immediately; no partial done or result_valid.
//  phase_cnt resets to 0 on every state transition and never wraps inside a phase.
//  Latency, start edge to done: 1 + LOAD_CYCLES + 2*WIDTH cycles.
//  load_x, load_y and spm_clr are never high in the same cycle as shift_en.
// TESTING
//  T1 WIDTH=8, LOAD_CYCLES=6, start at cycle 0:
//     load_x @1 only; load_y/spm_clr @1-6; shift_en @7-22; done @23 only; busy @1-22.
//  T2 Integration with SPM/SIPO, x=13, y=11 -> product 16'h008F when result_valid=1;
//     x=-3 (8'hFD), y=5 -> 16'hFFF1.
//  T3 Second start pulse at cycle 10 of MULT -> ignored; done still at cycle 23; single done pulse.
//  T4 clr at cycle 15 (MULT):
//     next cycle IDLE, all outputs 0; a later start gives full sequence timing as in T1.
//  T5 rst low at cycle 4 (LOAD):
//     outputs 0 asynchronously; after release, start works normally; no stale result_valid.
//  T6 In DONE, start and clr together -> IDLE, result_valid=0.
//     In DONE, start alone -> LOAD next cycle, result_valid=0.

Source files
------------

// File: rtl/mult_sequencer.sv
// mult_sequencer: Moore FSM sequencing one shift-add multiply (LOAD, MULT, DONE) per start pulse.
// Every output is registered from the next state, so strobes line up with the state they describe.
module mult_sequencer #(
  parameter int WIDTH       = 8,
  parameter int LOAD_CYCLES = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           start_i,
  output logic                           load_x_o,
  output logic                           load_y_o,
  output logic                           spm_clr_o,
  output logic                           shift_en_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           result_valid_o,
  output logic [$clog2(2*WIDTH+1)-1:0]   phase_cnt_o
);
  localparam int CW = $clog2(2*WIDTH+1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES-1);
  localparam logic [CW-1:0] MULT_LAST = CW'(2*WIDTH-1);
  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    out_q, out_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: if (cnt_q == LOAD_LAST) state_d = MULT; else cnt_d = cnt_q + 1'b1;
      MULT: if (cnt_q == MULT_LAST) state_d = DONE; else cnt_d = cnt_q + 1'b1;
      DONE: if (start_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    // load_x and done mark entry into their state, so they fire on the first cycle only
    out_d = {state_d == LOAD && state_q != LOAD,
             state_d == LOAD,
             state_d == LOAD,
             state_d == MULT,
             state_d == LOAD || state_d == MULT,
             state_d == DONE && state_q != DONE,
             state_d == DONE};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end
  assign {load_x_o, load_y_o, spm_clr_o, shift_en_o, busy_o, done_o, result_valid_o} = out_q;
  assign phase_cnt_o = cnt_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed sequences with a done/product scoreboard and a
// small shift-add datapath model driven by the sequencer strobes.
module tb_mult_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, start = 1'b0;
  logic       load_x, load_y, spm_clr, shift_en, busy, done, result_valid;
  logic [4:0] phase_cnt;
  logic [7:0] x_in = '0, y_in = '0;
  logic [15:0] xs = '0, ys = '0, pm = '0;
  int         bi = 0, cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {int cyc; logic [15:0] prod;} exp_t;
  exp_t       sb[$];

  mult_sequencer #(.WIDTH(8), .LOAD_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .start_i(start),
    .load_x_o(load_x), .load_y_o(load_y), .spm_clr_o(spm_clr), .shift_en_o(shift_en),
    .busy_o(busy), .done_o(done), .result_valid_o(result_valid), .phase_cnt_o(phase_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // serial-parallel multiplier stand-in: sign-extended operands, one partial product per shift cycle
  always @(posedge clk) begin
    if (load_x) xs <= {{8{x_in[7]}}, x_in};
    if (load_y) ys <= {{8{y_in[7]}}, y_in};
    if (spm_clr) begin
      pm <= '0;
      bi <= 0;
    end else if (shift_en) begin
      pm <= pm + (ys[bi] ? xs << bi : 16'h0);
      bi <= bi + 1;
    end
  end

  function automatic logic [11:0] obs();
    return {load_x, load_y, spm_clr, shift_en, busy, done, result_valid, phase_cnt};
  endfunction

  function automatic logic [11:0] exp_at(input int k);
    logic [4:0] pc;
    pc = (k >= 1 && k <= 6) ? 5'(k-1) : (k >= 7 && k <= 22) ? 5'(k-7) : 5'd0;
    return {k == 1, k >= 1 && k <= 6, k >= 1 && k <= 6, k >= 7 && k <= 22,
            k >= 1 && k <= 22, k == 23, k >= 23, pc};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] x, input logic [7:0] y, input bit push, input logic [15:0] prod);
    exp_t e;
    x_in = x;
    y_in = y;
    e.cyc = cyc + 23;
    e.prod = prod;
    if (push) sb.push_back(e);
    start = 1'b1;
  endtask

  task automatic run_seq(input string tag, input int last, input int poke_at);
    for (int k = 1; k <= last; k++) begin
      tick();
      start = (k == poke_at);
      chk($sformatf("%s_c%0d", tag, k), obs(), exp_at(k));
    end
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if ((load_x || load_y || spm_clr) && shift_en) begin
        n_fail++;
        $display("FAIL excl: load strobe with shift_en at cycle %0d", cyc);
      end
      if (done) begin
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: done at cycle %0d with nothing pending", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc || pm !== e.prod || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_check: cycle %0d prod %h rv %b, expected cycle %0d prod %h rv 1",
                     cyc, pm, result_valid, e.cyc, e.prod);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) tick();
    chk("reset", obs(), '0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle", obs(), '0);
    launch(8'd13, 8'd11, 1, 16'h008F);
    run_seq("t1", 25, 0);
    launch(8'hFD, 8'd5, 1, 16'hFFF1);
    run_seq("t2", 24, 0);
    launch(8'd7, 8'd9, 1, 16'h003F);
    run_seq("t3", 25, 17);
    launch(8'd2, 8'hFC, 0, 16'h0);
    run_seq("t4", 15, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr", obs(), '0);
    tick();
    chk("t4_idle", obs(), '0);
    launch(8'd2, 8'hFC, 1, 16'hFFF8);
    run_seq("t4b", 24, 0);
    launch(8'd3, 8'd3, 0, 16'h0);
    run_seq("t5", 4, 0);
    #2 rst_n = 1'b0;
    #1 chk("t5_async", obs(), '0);
    tick();
    chk("t5_held", obs(), '0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t5_after", obs(), '0);
    launch(8'hFF, 8'hFF, 1, 16'h0001);
    run_seq("t5b", 24, 0);
    start = 1'b1;
    clr = 1'b1;
    tick();
    start = 1'b0;
    clr = 1'b0;
    chk("t6_both", obs(), '0);
    repeat (3) begin
      tick();
      chk("t6_idle", obs(), '0);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d done pulses missing, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
